// File: rtl/mux4_arb_pkg.sv
// Shared definitions for the 4-source round-robin mux arbiter.
//   - arb_state_t / ST_IDLE / ST_OWNED : channel state encoding
//   - NUM_SRC, SEL_W                   : source count and select width
//   - onehot()                         : index to one-hot grant vector
//   - rr_pick()                        : first set request bit, searching
//                                        upward from a start index, mod 4
package mux4_arb_pkg;

  localparam int NUM_SRC = 4;
  localparam int SEL_W   = 2;

  typedef logic [0:0] arb_state_t;
  localparam arb_state_t ST_IDLE  = 1'b0;
  localparam arb_state_t ST_OWNED = 1'b1;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;

  function automatic logic [NUM_SRC-1:0] onehot(input logic [SEL_W-1:0] idx);
    return NUM_SRC'(1) << idx;
  endfunction

  // Walk from the farthest offset down to offset 0 so that the nearest
  // set bit (in search order) is the one left in the result.
  function automatic pick_t rr_pick(input logic [NUM_SRC-1:0] req,
                                    input logic [SEL_W-1:0]   start);
    pick_t            p;
    logic [SEL_W-1:0] idx;
    p.found = 1'b0;
    p.idx   = start;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      idx = start + SEL_W'(k);
      if (req[idx]) begin
        p.found = 1'b1;
        p.idx   = idx;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/mux4x2_en.sv
// 4-to-1 enabled data mux for the shared channel.
// Ports:
//   A, B, C, D : source data, DATA_W bits each
//   S          : select (0=A .. 3=D)
//   EN         : enable; Y is forced to zero when low
//   Y          : selected data, purely combinational
module mux4x2_en
  import mux4_arb_pkg::*;
#(
  parameter int DATA_W = 2
) (
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [DATA_W-1:0] C,
  input  logic [DATA_W-1:0] D,
  input  logic [SEL_W-1:0]  S,
  input  logic              EN,
  output logic [DATA_W-1:0] Y
);

  always_comb begin
    Y = '0;
    if (EN) begin
      case (S)
        2'd0:    Y = A;
        2'd1:    Y = B;
        2'd2:    Y = C;
        default: Y = D;
      endcase
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter/sequencer for a shared 4-to-1 enabled mux channel.
// Ports:
//   CLK        : clock, rising edge
//   RST        : asynchronous active-high reset
//   REQ[3:0]   : request bits, bit i = source i (0=A .. 3=D)
//   A, B, C, D : source data, DATA_W bits each
//   GNT[3:0]   : registered one-hot grant, zero when idle
//   S[1:0]     : registered select, holds its value while idle
//   EN         : registered enable, high exactly when GNT is nonzero
//   Y          : mux output driven from the registered S/EN
// Optional feature: define MUX4_ARB_TIMEOUT_EN to rotate an owner out after
// MAX_HOLD consecutive grant cycles whenever another source is requesting.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int DATA_W   = 2,
  parameter int MAX_HOLD = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_SRC-1:0] REQ,
  input  logic [DATA_W-1:0]  A,
  input  logic [DATA_W-1:0]  B,
  input  logic [DATA_W-1:0]  C,
  input  logic [DATA_W-1:0]  D,
  output logic [NUM_SRC-1:0] GNT,
  output logic [SEL_W-1:0]   S,
  output logic               EN,
  output logic [DATA_W-1:0]  Y
);

  if (MAX_HOLD < 1) begin : g_max_hold_check
    $error("mux4_rr_arbiter: MAX_HOLD must be >= 1");
  end

  arb_state_t         state_reg, state_next;
  logic [SEL_W-1:0]   last_reg, last_next;
  logic [SEL_W-1:0]   s_reg, s_next;
  logic [NUM_SRC-1:0] gnt_reg, gnt_next;
  logic               en_reg, en_next;

`ifdef MUX4_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  logic [CNT_W-1:0] cnt_reg, cnt_next;
`endif

  // While OWNED the owner is always last_reg, so both searches start at
  // last+1: from IDLE that is the round-robin position, from OWNED it is
  // owner+1.
  pick_t              pick_all, pick_other;
  logic [NUM_SRC-1:0] owner_mask;
  logic               take;
  logic [SEL_W-1:0]   take_idx;

  assign owner_mask = onehot(last_reg);
  assign pick_all   = rr_pick(REQ, last_reg + SEL_W'(1));
  assign pick_other = rr_pick(REQ & ~owner_mask, last_reg + SEL_W'(1));

  always_comb begin
    state_next = state_reg;
    last_next  = last_reg;
    s_next     = s_reg;
    gnt_next   = gnt_reg;
    en_next    = en_reg;
    take       = 1'b0;
    take_idx   = pick_all.idx;
`ifdef MUX4_ARB_TIMEOUT_EN
    cnt_next   = cnt_reg;
`endif

    case (state_reg)
      ST_IDLE: begin
        if (pick_all.found) begin
          take     = 1'b1;
          take_idx = pick_all.idx;
        end
      end
      default: begin
        if (!REQ[last_reg]) begin
          // Owner released: hand straight to the next requester, if any.
          if (pick_other.found) begin
            take     = 1'b1;
            take_idx = pick_other.idx;
          end else begin
            state_next = ST_IDLE;
            gnt_next   = '0;
            en_next    = 1'b0;
          end
`ifdef MUX4_ARB_TIMEOUT_EN
        end else if (cnt_reg == CNT_W'(MAX_HOLD - 1)) begin
          // Owner still requests, so the full search always finds someone;
          // it lands back on the owner only when nobody else is asking.
          take     = 1'b1;
          take_idx = pick_all.idx;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
`endif
        end
      end
    endcase

    if (take) begin
      state_next = ST_OWNED;
      last_next  = take_idx;
      s_next     = take_idx;
      gnt_next   = onehot(take_idx);
      en_next    = 1'b1;
`ifdef MUX4_ARB_TIMEOUT_EN
      cnt_next   = '0;
`endif
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg <= ST_IDLE;
      last_reg  <= SEL_W'(NUM_SRC - 1);
      s_reg     <= '0;
      gnt_reg   <= '0;
      en_reg    <= 1'b0;
`ifdef MUX4_ARB_TIMEOUT_EN
      cnt_reg   <= '0;
`endif
    end else begin
      state_reg <= state_next;
      last_reg  <= last_next;
      s_reg     <= s_next;
      gnt_reg   <= gnt_next;
      en_reg    <= en_next;
`ifdef MUX4_ARB_TIMEOUT_EN
      cnt_reg   <= cnt_next;
`endif
    end
  end

  assign GNT = gnt_reg;
  assign S   = s_reg;
  assign EN  = en_reg;

  mux4x2_en #(
    .DATA_W(DATA_W)
  ) u_mux (
    .A (A),
    .B (B),
    .C (C),
    .D (D),
    .S (s_reg),
    .EN(en_reg),
    .Y (Y)
  );

endmodule
